// File: rtl/wb_arb_pkg.sv
// Shared widths and the writeback request type used by the arbiter and its result FIFO.
package wb_arb_pkg;
  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer holding MDU results until they win the register-file write port.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  wb_req_t                            push_data,
  input  logic                               pop,
  output wb_req_t                            head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wb_req_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared pointers and count make old entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, MDU results queue behind it,
// with starvation relief and a pending-destination scoreboard for decode hazards.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_en,
  input  logic [REG_W-1:0]  pipe_wb_dest,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              mdu_valid,
  input  logic [REG_W-1:0]  mdu_dest,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic              issue_mdu,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic [REG_W-1:0]  issue_src_a,
  input  logic [REG_W-1:0]  issue_src_b,
  output logic              hazard_stall,
  output logic              pipe_hold,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]    fifo_count;
  wb_req_t             fifo_head, fifo_in, win;
  logic                fifo_push, fifo_pop, fifo_nempty;
  wb_req_t             rf_q, rf_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic                hold_q, hold_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign fifo_in = '{we: 1'b1, dest: mdu_dest, data: mdu_data};

  wb_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Ready depends only on the current count, so a full FIFO never passes a result through.
  always_comb begin
    fifo_nempty  = (fifo_count != '0);
    mdu_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
    fifo_push    = mdu_valid & mdu_ready;
    fifo_pop     = !pipe_wb_en & fifo_nempty;
    hazard_stall = pending_q[issue_src_a] | pending_q[issue_src_b]
                 | (issue_mdu & pending_q[issue_dest]);
  end

  always_comb begin
    win    = fifo_head;
    win.we = fifo_pop & fifo_head.we;
    if (pipe_wb_en) win = '{we: 1'b1, dest: pipe_wb_dest, data: pipe_wb_data};

    rf_d = '0;
    if (win.we) begin
      rf_d    = win;
      rf_d.we = (win.dest != '0);
    end

    starve_d = starve_q;
    if (fifo_pop)
      starve_d = '0;
    else if (fifo_nempty && pipe_wb_en && starve_q != SC_W'(STARVE_LIMIT))
      starve_d = starve_q + SC_W'(1);
    hold_d = (starve_d == SC_W'(STARVE_LIMIT)) && (starve_q != SC_W'(STARVE_LIMIT));

    // Set is applied after clear so a same-cycle issue to the retiring dest stays pending.
    pending_d = pending_q;
    if (fifo_pop) pending_d[fifo_head.dest] = 1'b0;
    if (issue_mdu && !hazard_stall && issue_dest != '0) pending_d[issue_dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q      <= '0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      rf_q      <= rf_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
    end
  end

  assign rf_we     = rf_q.we;
  assign rf_waddr  = rf_q.dest;
  assign rf_wdata  = rf_q.data;
  assign pipe_hold = hold_q;
endmodule
